// File: rtl/dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : dff_checker
// Purpose  : Response checker for a single-bit enable/reset D flip-flop.
//            Watches the observed DFF's rst/en/d inputs and its q output.
//            Runs an internal reference model of the flop and compares q
//            against that model on every clock edge of a run.
//            Reports pass/fail, a saturating mismatch count and the compare
//            index of the first mismatch.
// Ports    : clk           - clock, shared with the observed DFF
//            rst           - checker reset, synchronous, active-high
//            start         - pulse that arms a new check run
//            stop          - pulse that ends the current run
//            obs_rst       - observed DFF reset (polarity set by OBS_RST_HIGH)
//            obs_en        - observed DFF enable (polarity set by OBS_EN_HIGH)
//            obs_d         - observed DFF data input
//            obs_q         - observed DFF output
//            busy          - run in progress (SYNC or CHECK)
//            done          - run finished, held until next start or rst
//            pass          - done with zero mismatches
//            fail          - sticky, at least one mismatch this run
//            err_count     - mismatches this run, saturating
//            cyc_count     - compare cycles this run, saturating
//            first_err_cyc - cyc_count at first mismatch, all-ones if none
// Revision : 1.0 - initial release
// ============================================================================
module dff_checker #(
  parameter logic        OBS_RST_HIGH = 1'b1,
  parameter logic        OBS_EN_HIGH  = 1'b1,
  parameter logic        RST_VAL      = 1'b0,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_CYC      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             obs_rst,
  input  logic             obs_en,
  input  logic             obs_d,
  input  logic             obs_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] first_err_cyc
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_V    = MAX_CYC[CNT_W-1:0];
  localparam logic             MAX_EN   = (MAX_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  logic   exp_q;

  logic             rst_act;
  logic             en_act;
  logic             f_from_obs;
  logic             f_from_exp;
  logic             mismatch;
  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] err_inc;
  logic             max_hit;

  always_comb begin
    rst_act    = (obs_rst == OBS_RST_HIGH);
    en_act     = (obs_en == OBS_EN_HIGH);
    // Same next-state function applied to two different "current q" sources:
    // the observed q (used once to seed the model) and the model itself.
    f_from_obs = rst_act ? RST_VAL : (en_act ? obs_d : obs_q);
    f_from_exp = rst_act ? RST_VAL : (en_act ? obs_d : exp_q);
    // Case inequality so an X/Z on obs_q is reported, not silently matched.
    mismatch   = (obs_q !== exp_q);
    cyc_inc    = (cyc_count == ALL_ONES) ? cyc_count : (cyc_count + ONE);
    err_inc    = (err_count == ALL_ONES) ? err_count : (err_count + ONE);
    max_hit    = MAX_EN && (cyc_inc == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      err_count     <= '0;
      cyc_count     <= '0;
      first_err_cyc <= ALL_ONES;
      exp_q         <= RST_VAL;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_SYNC;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            err_count     <= '0;
            cyc_count     <= '0;
            first_err_cyc <= ALL_ONES;
          end
        end
        S_SYNC: begin
          // Seed the model from the real flop once; afterwards the model
          // evolves on its own so a corrupted q cannot mask later errors.
          exp_q <= f_from_obs;
          state <= S_CHECK;
        end
        S_CHECK: begin
          exp_q     <= f_from_exp;
          cyc_count <= cyc_inc;
          if (mismatch) begin
            err_count <= err_inc;
            fail      <= 1'b1;
            // fail is still clear only before the first mismatch of the run
            if (!fail) begin
              first_err_cyc <= cyc_count;
            end
          end
          // stop takes priority over any start seen on the same edge
          if (stop || max_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_checker
// Purpose  : Self-checking bench for dff_checker. Four instances cover the
//            default configuration, inverted control polarities, auto-finish
//            after MAX_CYC compares and a narrow saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_checker;

  logic clk;
  int   total;
  int   bad;

  typedef struct {
    logic [15:0] err;
    logic [15:0] cyc;
    logic        fl;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  exp_t ent;

  // ---------------- instance A : defaults ----------------
  logic        rst_a, start_a, stop_a, orst_a, oen_a, od_a, inv_a;
  logic        q_a = 1'b0;
  logic        obs_q_a;
  logic        busy_a, done_a, pass_a, fail_a;
  logic [15:0] err_a, cyc_a, first_a;

  assign obs_q_a = q_a ^ inv_a;

  always @(posedge clk) begin
    if (orst_a) q_a <= 1'b0;
    else if (oen_a) q_a <= od_a;
  end

  dff_checker u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a),
    .obs_rst(orst_a), .obs_en(oen_a), .obs_d(od_a), .obs_q(obs_q_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .err_count(err_a), .cyc_count(cyc_a), .first_err_cyc(first_a)
  );

  // ---------------- instance B : active-low rst/en ----------------
  logic        rst_o;
  logic        start_b, stop_b, orst_b, oen_b, od_b, obs_q_b;
  logic        busy_b, done_b, pass_b, fail_b;
  logic [15:0] err_b, cyc_b, first_b;

  dff_checker #(.OBS_RST_HIGH(1'b0), .OBS_EN_HIGH(1'b0)) u_b (
    .clk(clk), .rst(rst_o), .start(start_b), .stop(stop_b),
    .obs_rst(orst_b), .obs_en(oen_b), .obs_d(od_b), .obs_q(obs_q_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .err_count(err_b), .cyc_count(cyc_b), .first_err_cyc(first_b)
  );

  // ---------------- instance C : MAX_CYC = 8 ----------------
  logic        start_c, stop_c, orst_c, oen_c, od_c, obs_q_c;
  logic        busy_c, done_c, pass_c, fail_c;
  logic [15:0] err_c, cyc_c, first_c;

  dff_checker #(.MAX_CYC(8)) u_c (
    .clk(clk), .rst(rst_o), .start(start_c), .stop(stop_c),
    .obs_rst(orst_c), .obs_en(oen_c), .obs_d(od_c), .obs_q(obs_q_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c),
    .err_count(err_c), .cyc_count(cyc_c), .first_err_cyc(first_c)
  );

  // ---------------- instance D : CNT_W = 4 ----------------
  logic        start_d, stop_d, orst_d, oen_d, od_d, obs_q_d;
  logic        busy_d, done_d, pass_d, fail_d;
  logic [3:0]  err_d, cyc_d, first_d;

  dff_checker #(.CNT_W(4)) u_d (
    .clk(clk), .rst(rst_o), .start(start_d), .stop(stop_d),
    .obs_rst(orst_d), .obs_en(oen_d), .obs_d(od_d), .obs_q(obs_q_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .fail(fail_d),
    .err_count(err_d), .cyc_count(cyc_d), .first_err_cyc(first_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n compare cycles of random stimulus into A; obs_q is inverted only
  // at compare index bad_k. Stop is raised on the last cycle when use_stop.
  task automatic run_a(input int n, input int bad_k, input bit use_stop);
    int e;
    e = 0;
    for (int k = 0; k < n; k++) begin
      orst_a = ($urandom_range(0, 3) == 0);
      oen_a  = 1'($urandom_range(0, 1));
      od_a   = 1'($urandom_range(0, 1));
      inv_a  = (k == bad_k);
      stop_a = use_stop && (k == n - 1);
      if (k == bad_k) e++;
      ent.err = 16'(e); ent.cyc = 16'(k + 1); ent.fl = (e != 0); ent.bsy = 1'b1;
      sb.push_back(ent);
      tick();
      ent = sb.pop_front();
      total++;
      if (err_a !== ent.err || cyc_a !== ent.cyc || fail_a !== ent.fl) begin
        bad++;
        $display("FAIL run_a k=%0d: got err=%0d cyc=%0d fail=%b, need err=%0d cyc=%0d fail=%b",
                 k, err_a, cyc_a, fail_a, ent.err, ent.cyc, ent.fl);
      end
    end
    inv_a  = 1'b0;
    stop_a = 1'b0;
  endtask

  // start pulse then the SYNC edge; checks the SYNC-state outputs on the way
  task automatic arm_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || pass_a !== 1'b0 || fail_a !== 1'b0 ||
        err_a !== 16'd0 || cyc_a !== 16'd0 || first_a !== 16'hFFFF) begin
      bad++;
      $display("FAIL arm_a: got busy=%b done=%b pass=%b fail=%b err=%0d cyc=%0d first=%h, need 1 0 0 0 0 0 ffff",
               busy_a, done_a, pass_a, fail_a, err_a, cyc_a, first_a);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_o = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_o = 1'b0;
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || fail_a !== 1'b0 ||
        err_a !== 16'd0 || cyc_a !== 16'd0 || first_a !== 16'hFFFF) begin
      bad++;
      $display("FAIL reset_a: got busy=%b done=%b pass=%b fail=%b err=%0d cyc=%0d first=%h, need 0 0 0 0 0 0 ffff",
               busy_a, done_a, pass_a, fail_a, err_a, cyc_a, first_a);
    end
    total++;
    if (first_d !== 4'hF || err_d !== 4'h0 || busy_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_d: got first=%h err=%h busy=%b, need f 0 0", first_d, err_d, busy_d);
    end
  endtask

  task automatic test_clean_run();
    arm_a();
    run_a(20, -1, 1'b1);
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 16'd0 ||
        cyc_a !== 16'd20 || first_a !== 16'hFFFF) begin
      bad++;
      $display("FAIL clean_run: got busy=%b done=%b pass=%b err=%0d cyc=%0d first=%h, need 0 1 1 0 20 ffff",
               busy_a, done_a, pass_a, err_a, cyc_a, first_a);
    end
  endtask

  // Restarts straight from DONE, so also covers back-to-back runs.
  task automatic test_single_error();
    arm_a();
    run_a(20, 5, 1'b1);
    total++;
    if (done_a !== 1'b1 || pass_a !== 1'b0 || fail_a !== 1'b1 || err_a !== 16'd1 ||
        first_a !== 16'd5 || cyc_a !== 16'd20) begin
      bad++;
      $display("FAIL single_error: got done=%b pass=%b fail=%b err=%0d first=%0d cyc=%0d, need 1 0 1 1 5 20",
               done_a, pass_a, fail_a, err_a, first_a, cyc_a);
    end
    tick();
    total++;
    if (done_a !== 1'b1 || pass_a !== 1'b0) begin
      bad++;
      $display("FAIL done_hold: got done=%b pass=%b, need 1 0", done_a, pass_a);
    end
  endtask

  task automatic test_polarity();
    orst_b = 1'b1; oen_b = 1'b1; od_b = 1'b0; obs_q_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      od_b   = ~od_b;
      stop_b = (k == 9);
      ent.err = 16'd0; ent.cyc = 16'(k + 1); ent.fl = 1'b0; ent.bsy = 1'b1;
      sb.push_back(ent);
      tick();
      ent = sb.pop_front();
      total++;
      if (err_b !== ent.err || cyc_b !== ent.cyc || fail_b !== ent.fl) begin
        bad++;
        $display("FAIL polarity k=%0d: got err=%0d cyc=%0d fail=%b, need err=%0d cyc=%0d fail=%b",
                 k, err_b, cyc_b, fail_b, ent.err, ent.cyc, ent.fl);
      end
    end
    stop_b = 1'b0;
    total++;
    if (done_b !== 1'b1 || pass_b !== 1'b1) begin
      bad++;
      $display("FAIL polarity_end: got done=%b pass=%b, need 1 1", done_b, pass_b);
    end
  endtask

  task automatic test_max_cyc();
    orst_c = 1'b1; oen_c = 1'b0; od_c = 1'b0; obs_q_c = 1'b0; stop_c = 1'b0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      ent.err = 16'd0; ent.cyc = 16'(k + 1); ent.fl = 1'b0; ent.bsy = (k != 7);
      sb.push_back(ent);
      tick();
      ent = sb.pop_front();
      total++;
      if (busy_c !== ent.bsy || done_c !== !ent.bsy || cyc_c !== ent.cyc) begin
        bad++;
        $display("FAIL max_cyc k=%0d: got busy=%b done=%b cyc=%0d, need busy=%b done=%b cyc=%0d",
                 k, busy_c, done_c, cyc_c, ent.bsy, !ent.bsy, ent.cyc);
      end
    end
    tick();
    total++;
    if (done_c !== 1'b1 || pass_c !== 1'b1 || cyc_c !== 16'd8) begin
      bad++;
      $display("FAIL max_cyc_hold: got done=%b pass=%b cyc=%0d, need 1 1 8", done_c, pass_c, cyc_c);
    end
  endtask

  task automatic test_saturate();
    orst_d = 1'b1; oen_d = 1'b0; od_d = 1'b0; obs_q_d = 1'b1;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      stop_d = (k == 19);
      ent.err = 16'((k + 1 > 15) ? 15 : k + 1);
      ent.cyc = ent.err; ent.fl = 1'b1; ent.bsy = 1'b1;
      sb.push_back(ent);
      tick();
      ent = sb.pop_front();
      total++;
      if ({12'd0, err_d} !== ent.err || {12'd0, cyc_d} !== ent.cyc || fail_d !== ent.fl) begin
        bad++;
        $display("FAIL saturate k=%0d: got err=%0d cyc=%0d fail=%b, need err=%0d cyc=%0d fail=%b",
                 k, err_d, cyc_d, fail_d, ent.err, ent.cyc, ent.fl);
      end
    end
    stop_d = 1'b0;
    total++;
    if (err_d !== 4'hF || first_d !== 4'h0 || pass_d !== 1'b0 || done_d !== 1'b1) begin
      bad++;
      $display("FAIL saturate_end: got err=%h first=%h pass=%b done=%b, need f 0 0 1",
               err_d, first_d, pass_d, done_d);
    end
  endtask

  task automatic test_mid_reset();
    arm_a();
    run_a(3, 1, 1'b0);
    rst_a = 1'b1; start_a = 1'b1;
    orst_a = 1'b0; oen_a = 1'b0;
    tick();
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || fail_a !== 1'b0 ||
        err_a !== 16'd0 || cyc_a !== 16'd0 || first_a !== 16'hFFFF) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b pass=%b fail=%b err=%0d cyc=%0d first=%h, need 0 0 0 0 0 0 ffff",
               busy_a, done_a, pass_a, fail_a, err_a, cyc_a, first_a);
    end
    rst_a = 1'b0; start_a = 1'b0;
    tick();
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b, need 0 0", busy_a, done_a);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_a = 1'b1; rst_o = 1'b1;
    start_a = 1'b0; stop_a = 1'b0; orst_a = 1'b1; oen_a = 1'b0; od_a = 1'b0; inv_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; orst_b = 1'b1; oen_b = 1'b1; od_b = 1'b0; obs_q_b = 1'b1;
    start_c = 1'b0; stop_c = 1'b0; orst_c = 1'b1; oen_c = 1'b0; od_c = 1'b0; obs_q_c = 1'b0;
    start_d = 1'b0; stop_d = 1'b0; orst_d = 1'b1; oen_d = 1'b0; od_d = 1'b0; obs_q_d = 1'b1;
    test_reset();
    test_clean_run();
    test_single_error();
    test_polarity();
    test_max_cyc();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
